// File: rtl/rx_uart.sv
// UART receiver: 16x oversampled, mid-bit start validation, LSB-first data, stop check.
// Optional even-parity bit between data and stop is enabled by defining RX_UART_PARITY_EN.
module rx_uart #(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_s_tick,
  input  logic             i_rx,
  output logic [D_BIT-1:0] o_data,
  output logic             o_rx_done_tick,
  output logic             o_frame_err,
  output logic             o_parity_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_UART_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_e;

  localparam logic [3:0] N_LAST = 4'(D_BIT - 1);
  localparam logic [4:0] S_LAST = 5'(SB_TICK - 1);
`ifdef RX_UART_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif

  logic             rx_meta, rx_s;
  state_e           state_q, state_d;
  logic [4:0]       s_q, s_d;
  logic [3:0]       n_q, n_d;
  logic [D_BIT-1:0] b_q, b_d;
  logic [D_BIT-1:0] data_d;
  logic             done_d, ferr_d;
`ifdef RX_UART_PARITY_EN
  logic             perr_q, perr_d, perr_out_d;
`endif

  // NOTE: defaults are assigned first so every path drives every signal and no latch is inferred.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = o_data;
    done_d  = 1'b0;
    ferr_d  = o_frame_err;
`ifdef RX_UART_PARITY_EN
    perr_d     = perr_q;
    perr_out_d = o_parity_err;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_q == 5'd7) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;  // start bit gone by mid-bit: treat as a glitch
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_q == 5'd15) begin
            b_d = {rx_s, b_q[D_BIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) state_d = AFTER_DATA;
            else               n_d     = n_q + 4'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef RX_UART_PARITY_EN
      PARITY: begin
        if (i_s_tick) begin
          if (s_q == 5'd15) begin
            perr_d  = (^b_q) ^ rx_s;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (i_s_tick) begin
          if (s_q == S_LAST) begin
            data_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
`ifdef RX_UART_PARITY_EN
            perr_out_d = perr_q;
`endif
            state_d = rx_s ? IDLE : BREAK;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      BREAK: begin
        // a held-low line must return high before another start edge is accepted
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta        <= 1'b1;
      rx_s           <= 1'b1;
      state_q        <= IDLE;
      s_q            <= '0;
      n_q            <= '0;
      b_q            <= '0;
      o_data         <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
`ifdef RX_UART_PARITY_EN
      perr_q         <= 1'b0;
      o_parity_err   <= 1'b0;
`endif
    end else begin
      rx_meta        <= i_rx;
      rx_s           <= rx_meta;
      state_q        <= state_d;
      s_q            <= s_d;
      n_q            <= n_d;
      b_q            <= b_d;
      o_data         <= data_d;
      o_rx_done_tick <= done_d;
      o_frame_err    <= ferr_d;
`ifdef RX_UART_PARITY_EN
      perr_q         <= perr_d;
      o_parity_err   <= perr_out_d;
`endif
    end
  end

`ifndef RX_UART_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: directed scenarios plus random frames against a frame-queue model.
module tb_rx_uart;
  localparam int D_BIT   = 8;
  localparam int SB_TICK = 16;

  logic             clk    = 1'b0;
  logic             reset  = 1'b1;
  logic             s_tick = 1'b0;
  logic             rx     = 1'b1;
  logic [D_BIT-1:0] data;
  logic             done, ferr, perr;

  rx_uart #(.D_BIT(D_BIT), .SB_TICK(SB_TICK)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_s_tick       (s_tick),
    .i_rx           (rx),
    .o_data         (data),
    .o_rx_done_tick (done),
    .o_frame_err    (ferr),
    .o_parity_err   (perr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D_BIT-1:0] data;
    logic             ferr;
    logic             perr;
  } frame_t;

  frame_t exp_q[$];
  frame_t hold;
  int     tests  = 0;
  int     fails  = 0;
  int     pulses = 0;
  int     phase  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one-clock tick every 4 clocks
  initial begin
    forever begin
      @(posedge clk);
      #1;
      s_tick = (phase == 3);
      phase  = (phase + 1) % 4;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #2;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [D_BIT-1:0] d, input logic stop, input logic pbit,
                            input bit expect_it);
    frame_t f;
    f.data = d;
    f.ferr = ~stop;
`ifdef RX_UART_PARITY_EN
    f.perr = (^d) ^ pbit;
`else
    f.perr = 1'b0 & pbit;
`endif
    if (expect_it) exp_q.push_back(f);
    drive_bit(1'b0, 16);
    for (int i = 0; i < D_BIT; i++) drive_bit(d[i], 16);
`ifdef RX_UART_PARITY_EN
    drive_bit(pbit, 16);
`endif
    drive_bit(stop, SB_TICK);
  endtask

  // compare process: every done pulse must match the next queued frame, otherwise outputs hold
  initial begin
    hold = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = '0;
        exp_q.delete();
      end else if (done) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          hold = exp_q.pop_front();
          check("frame_data", 32'(data), 32'(hold.data));
          check("frame_ferr", 32'(ferr), 32'(hold.ferr));
          check("frame_perr", 32'(perr), 32'(hold.perr));
        end
      end else begin
        check("hold_outputs", 32'({data, ferr, perr}), 32'(hold));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    int p;
    logic [D_BIT-1:0] d;
    logic stop, pbit;
    int gap;

    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_data", 32'(data), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_perr", 32'(perr), 32'h0);
    drive_bit(1'b1, 20);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_ferr", 32'(ferr), 32'h0);
    check("a5_pulses", 32'(pulses), 32'd1);

    p = pulses;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 20);
    check("glitch_no_pulse", 32'(pulses), 32'(p));
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    check("3c_data", 32'(data), 32'h3C);

    p = pulses;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 40);
    check("break_one_pulse", 32'(pulses), 32'(p + 1));
    check("break_ferr", 32'(ferr), 32'h1);
    check("break_data", 32'(data), 32'h12);
    drive_bit(1'b1, 4);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
    check("7e_data", 32'(data), 32'h7E);
    check("7e_ferr", 32'(ferr), 32'h0);

    p = pulses;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 16);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_data", 32'(data), 32'h0);
    check("midreset_ferr", 32'(ferr), 32'h0);
    check("midreset_perr", 32'(perr), 32'h0);
    check("midreset_no_pulse", 32'(pulses), 32'(p));
    drive_bit(1'b1, 20);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    check("81_data", 32'(data), 32'h81);

    drive_bit(1'b1, 4);
    p = pulses;
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    check("b2b_first", 32'(data), 32'h00);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    check("b2b_second", 32'(data), 32'hFF);
    check("b2b_pulses", 32'(pulses), 32'(p + 2));

`ifdef RX_UART_PARITY_EN
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    check("par_bad", 32'(perr), 32'h1);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    check("par_good", 32'(perr), 32'h0);
`endif

    for (int k = 0; k < 16; k++) begin
      d    = D_BIT'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pbit = 1'($urandom);
      send_frame(d, stop, pbit, 1'b1);
      gap = stop ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5));
      if (gap > 0) drive_bit(1'b1, gap);
    end

    drive_bit(1'b1, 10);
    check("all_frames_received", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
